// File: rtl/risc_defs.sv
// risc_defs: shared widths, reset/increment defaults, NOP and fetch FSM encodings for RISC_PROC.
package risc_defs;
    localparam int          DATA_W      = 16;
    localparam logic [15:0] RESET_VEC_D = 16'h0000;
    localparam logic [15:0] PC_INC_D    = 16'h0001;
    localparam logic [15:0] NOP         = 16'h0000;
    localparam logic [1:0]  BOOT        = 2'd0;
    localparam logic [1:0]  FETCH       = 2'd1;
    localparam logic [1:0]  HOLD        = 2'd2;
endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter with load (priority), modulo-2^16 increment and hold.
module pc_reg
    import risc_defs::*;
#(
    parameter logic [DATA_W-1:0] RESET_VEC = RESET_VEC_D,
    parameter logic [DATA_W-1:0] PC_INC    = PC_INC_D
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              inc,
    input  logic [DATA_W-1:0] load_val,
    output logic [DATA_W-1:0] pc
);
    always_ff @(posedge clk)
        if (rst)       pc <= RESET_VEC;
        else if (load) pc <= load_val;
        else if (inc)  pc <= pc + PC_INC;
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: IF stage - PC, imem request/ready handshake and IF/ID instruction register.
// Optional FETCH_STALL_CNT_EN adds a saturating stall_cnt of wait/HOLD cycles.
module pc_fetch_unit
    import risc_defs::*;
#(
    parameter logic [DATA_W-1:0] RESET_VEC = RESET_VEC_D,
    parameter logic [DATA_W-1:0] PC_INC    = PC_INC_D
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              br_taken,
    input  logic [DATA_W-1:0] br_target,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [DATA_W-1:0] imem_data,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] pc_seq
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);
    logic [1:0]        state, state_n;
    logic [DATA_W-1:0] pc;
    logic              redirect, fire;

    assign redirect  = br_taken && state != BOOT;
    assign fire      = state == FETCH && imem_ready && !br_taken && !flush;
    assign imem_req  = state == FETCH;
    assign imem_addr = pc;
    assign pc_seq    = pc_out + PC_INC;

    pc_reg #(.RESET_VEC(RESET_VEC), .PC_INC(PC_INC)) u_pc (
        .clk(clk), .rst(rst), .load(redirect), .inc(fire), .load_val(br_target), .pc(pc)
    );

    always_comb
        state_n = (state == BOOT || redirect) ? FETCH :
                  state == HOLD               ? (stall ? HOLD : FETCH) :
                  (fire && stall)             ? HOLD : FETCH;

    always_ff @(posedge clk)
        if (rst) begin
            state    <= BOOT;
            ir       <= NOP;
            ir_valid <= 1'b0;
            pc_out   <= RESET_VEC;
        end else begin
            state <= state_n;
            if (fire) begin
                ir     <= imem_data;
                pc_out <= pc;
            end
            // a wait cycle bubbles the IR unless the hazard unit is holding it
            ir_valid <= (redirect || flush)       ? 1'b0 :
                        fire                      ? 1'b1 :
                        (state == FETCH && !stall) ? 1'b0 : ir_valid;
        end

`ifdef FETCH_STALL_CNT_EN
    always_ff @(posedge clk)
        if (rst)
            stall_cnt <= 16'h0000;
        else if (((state == FETCH && !imem_ready) || state == HOLD) && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'h0001;
`endif
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch stage of the 16-bit RISC_PROC pipeline.
- Owns the program counter and issues instruction-memory requests with a request/ready handshake.
- Latches the returned instruction into the IF/ID instruction register.
- Its pc_out feeds the downstream 16-bit adder, which forms the branch target. It accepts that target back as br_target.

Parameters:
- RESET_VEC, 16'h0000, PC value loaded on reset.
- PC_INC, 16'h0001, sequential PC increment (word-addressed memory).
- DATA_W, 16, instruction and address width; the design is fixed at 16.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hazard unit: hold the IR and PC; issue no new fetch.
- flush  input  1  squash the IR contents (ir_valid=0); the PC is unchanged.
- br_taken  input  1  redirect the PC this cycle.
- br_target  input  16  redirect address, from the branch-target adder output.
- imem_req  output  1  fetch request valid.
- imem_addr  output  16  fetch address; always equals the current PC.
- imem_ready  input  1  memory returns imem_data for imem_addr this cycle.
- imem_data  input  16  instruction word.
- ir  output  16  latched instruction.
- ir_valid  output  1  ir holds a live instruction.
- pc_out  output  16  PC of the instruction in ir; feeds the adder.
- pc_seq  output  16  pc_out + PC_INC (combinational), for link/return use.

Behaviour:
- Reset (rst=1 at a clk edge): pc=RESET_VEC, ir=16'h0000, ir_valid=0, pc_out=RESET_VEC, state=BOOT, imem_req=0.
- Reset mid-fetch abandons the request. A coincident imem_ready is ignored.
- States:
  - BOOT: one idle cycle after reset, then go to FETCH.
  - FETCH: imem_req=1.
  - HOLD: IR is valid and stalled; imem_req=0.
- FETCH with imem_ready=1 and no br_taken/flush:
  - ir<=imem_data, pc_out<=pc, ir_valid<=1, pc<=pc+PC_INC.
  - Stay in FETCH if stall=0; go to HOLD if stall=1.
- FETCH with imem_ready=0: pc holds, imem_req stays 1, and ir_valid<=0 (bubble) unless stall=1.
- Fetch latency: 1 cycle from ready to ir_valid. Back-to-back ready gives one instruction per cycle.
- HOLD: ir, pc_out, pc and ir_valid all hold while stall=1. When stall=0, return to FETCH next cycle.
- br_taken=1 (any state except BOOT):
  - pc<=br_target, ir_valid<=0, next state FETCH.
  - Any imem_ready that cycle is discarded.
  - br_taken has priority over stall and imem_ready.
- flush=1 without br_taken: ir_valid<=0; pc is unchanged. A coincident ready's data is discarded and pc does not advance.
- Priority, high to low: rst, br_taken, flush, stall, imem_ready.
- Arithmetic: modulo-2^16, so pc=16'hFFFF with PC_INC=1 wraps to 16'h0000. No overflow flag.
- imem_addr is stable while imem_req=1 and imem_ready=0, unless br_taken or rst.

Optional Feature:
- Macro: FETCH_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt[15:0].
  - Increments by 1 on each cycle with state FETCH and imem_req=1 and imem_ready=0, or state HOLD.
  - Saturates at 16'hFFFF.
  - Cleared by rst.
- When undefined: no port and no counter logic. All other behaviour is identical.

Decomposition:
- Shared package/include (risc_defs):
  - Constants: DATA_W=16, RESET_VEC, PC_INC, NOP encoding 16'h0000.
  - State encodings BOOT=2'd0, FETCH=2'd1, HOLD=2'd2.
- One sub-module: pc_reg, the 16-bit PC register with load/increment/hold controls.
- The FSM and IR latch stay in pc_fetch_unit.

Test Plan:
- Reset then ready held 1 with data 16'hA001, A002, A003:
  - imem_addr goes 0000, 0001, 0002.
  - ir follows one cycle later with pc_out 0000, 0001, 0002.
  - imem_req=0 in the BOOT cycle.
- imem_ready low for 3 cycles at pc=0005:
  - imem_addr holds 0005 and ir_valid=0 during the wait.
  - When ready is raised with 16'h1234: ir=1234, pc_out=0005, next addr=0006.
- stall=1 for 2 cycles after ir=16'hBEEF is latched:
  - ir, pc_out and ir_valid hold.
  - imem_req=0.
  - Fetch resumes at pc+1 after stall drops.
- br_taken=1, br_target=16'h0040, coincident with imem_ready:
  - Data is discarded and ir_valid=0.
  - Next imem_addr=0040.
  - Also test br_taken with stall=1: the branch wins.
- Wrap: force pc=FFFF and return ready, giving pc_out=FFFF and next imem_addr=0000. Then assert rst mid-wait: pc returns to RESET_VEC and ir_valid=0.
- With FETCH_STALL_CNT_EN: 5 wait cycles plus 2 HOLD cycles gives stall_cnt=7, and rst clears it to 0.
